alu_issue: RTL

Operation-issue stage that drives the ALU's 4-bit `Operation` code and consumes its `ALUResult` for branch resolution. Decodes `ALUOp`/`Funct3`/`Funct7`/`RType` from the decode stage into the ALU operation encoding. Buffers decoded operations in a 2-entry valid/ready FIFO between decode and execute. Sits directly in front of the ALU in the execute stage.

---
 rtl/alu_issue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// ALU operation issue stage: decodes ALUOp/Funct3/Funct7 into the ALU op code,
// buffers it in a 2-entry FIFO and resolves branch outcome. Option: ALU_ISSUE_PERF_CNT_EN.
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     RType,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Branch,
    output logic                     IllegalOp,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     BranchTaken
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]              IssueCount,
    output logic [31:0]              TakenCount
`endif
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);

    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] op;
        logic                     br;
        logic                     ill;
    } entry_t;

    entry_t     dec;
    entry_t     mem [2];
    entry_t     head;
    logic       rptr;
    logic       wptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       unused_bits;

    // Only Funct7[5] and ALUResult[0] carry meaning here.
    assign unused_bits = ^{ALUResult[DATA_WIDTH-1:1], Funct7[6], Funct7[4:0]};

    // Decode the incoming instruction into the entry that will be stored.
    always_comb begin
        dec = '0;
        unique case (1'b1)
            ALUOp == 2'b00: dec.op = OP_ADD;
            ALUOp == 2'b01: begin
                dec.br = 1'b1;
                case (Funct3)
                    3'b000:  dec.op  = OP_BEQ;
                    3'b001:  dec.op  = OP_BNE;
                    3'b100:  dec.op  = OP_BLT;
                    3'b101:  dec.op  = OP_BGE;
                    default: dec.ill = 1'b1;
                endcase
            end
            ALUOp == 2'b10: begin
                case (Funct3)
                    3'b000: begin
                        if (RType && Funct7[5])
                            dec.op = OP_SUB;
                        else
                            dec.op = OP_ADD;
                    end
                    3'b100:  dec.op  = OP_XOR;
                    3'b110:  dec.op  = OP_OR;
                    3'b111:  dec.op  = OP_AND;
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rptr];

    // Head fields are masked so an empty FIFO presents a quiet interface.
    always_comb begin
        Operation   = '0;
        Branch      = 1'b0;
        IllegalOp   = 1'b0;
        BranchTaken = 1'b0;
        if (out_valid) begin
            Operation   = head.op;
            Branch      = head.br;
            IllegalOp   = head.ill;
            BranchTaken = head.br && ALUResult[0];
        end
    end

    // Occupancy and pointer bookkeeping; flush discards same-cycle traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
        end else begin
            if (push)
                wptr <= ~wptr;
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem[wptr] <= dec;
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    // Issue and taken-branch counters survive flush, wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            IssueCount <= 32'd0;
            TakenCount <= 32'd0;
        end else if (pop && !flush) begin
            IssueCount <= IssueCount + 32'd1;
            if (BranchTaken)
                TakenCount <= TakenCount + 32'd1;
        end
    end
`endif

endmodule
